// File: rtl/dtof_acq_sequencer.sv
// Frame sequencer for the two-pass dToF histogram datapath: clear, coarse acquisition,
// coarse peak, zoom window, clear, fine acquisition, fine peak -> {peak_ch, peak_fh}.
module dtof_acq_sequencer #(
  parameter int NB      = 5,
  parameter int CYC_CH  = 64,
  parameter int CYC_FH  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            res_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            tdc_valid_i,
  input  logic            cyc_end_i,
  input  logic            peak_done_i,
  input  logic [NB-1:0]   peak_ch_i,
  input  logic [NB-1:0]   peak_fh_i,
  input  logic            alg_ready_i,
  output logic            wr_en_o,
  output logic            his_num_o,
  output logic            clr_en_o,
  output logic [NB-1:0]   clr_addr_o,
  output logic            acq_finish_o,
  output logic            busy_o,
  output logic [2*NB-1:0] depth_o,
  output logic            depth_valid_o,
  output logic            err_o
);

  localparam int CYC_MAX = (CYC_CH > CYC_FH) ? CYC_CH : CYC_FH;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CYC_CH_LAST = CW'(CYC_CH - 1);
  localparam logic [CW-1:0] CYC_FH_LAST = CW'(CYC_FH - 1);
  localparam logic [CW-1:0] CYC_ONE     = CW'(1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE      = TW'(1);
  localparam logic [NB-1:0] ADDR_LAST   = '1;
  localparam logic [NB-1:0] ADDR_ONE    = NB'(1);

  typedef enum logic [2:0] {
    IDLE, CLR_CH, ACQ_CH, WAIT_PK_CH, WAIT_ALG, CLR_FH, ACQ_FH, WAIT_PK_FH
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cyc_q;
  logic [TW-1:0]     wcnt_q;
  logic [NB-1:0]     pch_q;
  logic [NB-1:0]     clr_addr_q;
  logic [2*NB-1:0]   depth_q;
  logic              his_num_q, clr_en_q, acq_finish_q, busy_q, depth_valid_q, err_q;
  logic              in_acq, wait_hit;
  logic [CW-1:0]     cyc_last;

  assign in_acq   = (state_q == ACQ_CH) || (state_q == ACQ_FH);
  assign cyc_last = (state_q == ACQ_CH) ? CYC_CH_LAST : CYC_FH_LAST;

  // Write strobe must follow tdc_valid in the same clock, so it stays combinational.
  assign wr_en_o = tdc_valid_i & in_acq & ~abort_i;

  always_comb begin
    wait_hit = 1'b0;
    case (state_q)
      WAIT_PK_CH, WAIT_PK_FH: wait_hit = peak_done_i;
      WAIT_ALG:               wait_hit = alg_ready_i;
      default:                wait_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      wcnt_q        <= '0;
      pch_q         <= '0;
      clr_addr_q    <= '0;
      depth_q       <= '0;
      his_num_q     <= 1'b0;
      clr_en_q      <= 1'b0;
      acq_finish_q  <= 1'b0;
      busy_q        <= 1'b0;
      depth_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      acq_finish_q  <= 1'b0;
      depth_valid_q <= 1'b0;
      if (abort_i) begin
        state_q    <= IDLE;
        clr_en_q   <= 1'b0;
        clr_addr_q <= '0;
        his_num_q  <= 1'b0;
        busy_q     <= 1'b0;
        cyc_q      <= '0;
        wcnt_q     <= '0;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            state_q    <= CLR_CH;
            err_q      <= 1'b0;
            clr_en_q   <= 1'b1;
            clr_addr_q <= '0;
            his_num_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
          CLR_CH, CLR_FH: begin
            if (clr_addr_q == ADDR_LAST) begin
              state_q    <= (state_q == CLR_CH) ? ACQ_CH : ACQ_FH;
              clr_en_q   <= 1'b0;
              clr_addr_q <= '0;
              cyc_q      <= '0;
            end else begin
              clr_addr_q <= clr_addr_q + ADDR_ONE;
            end
          end
          ACQ_CH, ACQ_FH: if (cyc_end_i) begin
            if (cyc_q == cyc_last) begin
              state_q      <= (state_q == ACQ_CH) ? WAIT_PK_CH : WAIT_PK_FH;
              acq_finish_q <= 1'b1;
              cyc_q        <= '0;
              wcnt_q       <= '0;
            end else begin
              cyc_q <= cyc_q + CYC_ONE;
            end
          end
          default: begin
            // All three WAIT states share one timeout counter, cleared on every entry.
            if (wait_hit) begin
              wcnt_q <= '0;
              case (state_q)
                WAIT_PK_CH: begin
                  pch_q   <= peak_ch_i;
                  state_q <= WAIT_ALG;
                end
                WAIT_ALG: begin
                  state_q    <= CLR_FH;
                  his_num_q  <= 1'b1;
                  clr_en_q   <= 1'b1;
                  clr_addr_q <= '0;
                end
                default: begin
                  depth_q       <= {pch_q, peak_fh_i};
                  depth_valid_q <= 1'b1;
                  state_q       <= IDLE;
                  his_num_q     <= 1'b0;
                  busy_q        <= 1'b0;
                end
              endcase
            end else if (wcnt_q == TO_LAST) begin
              err_q     <= 1'b1;
              state_q   <= IDLE;
              his_num_q <= 1'b0;
              busy_q    <= 1'b0;
              wcnt_q    <= '0;
            end else begin
              wcnt_q <= wcnt_q + TO_ONE;
            end
          end
        endcase
      end
    end
  end

  assign his_num_o     = his_num_q;
  assign clr_en_o      = clr_en_q;
  assign clr_addr_o    = clr_addr_q;
  assign acq_finish_o  = acq_finish_q;
  assign busy_o        = busy_q;
  assign depth_o       = depth_q;
  assign depth_valid_o = depth_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_dtof_acq_sequencer.sv
// Scenario bench for dtof_acq_sequencer (NB=5, 4 laser cycles per pass, 16-clock wait timeout).
module tb_dtof_acq_sequencer;
  localparam int NB = 5;
  localparam int CYC = 4;
  localparam int TO = 16;

  logic clk = 0, res_n = 0, start = 0, abort = 0, tdc_valid = 0, cyc_end = 0;
  logic peak_done = 0, alg_ready = 0;
  logic [NB-1:0] peak_ch = '0, peak_fh = '0;
  logic wr_en, his_num, clr_en, acq_finish, busy, depth_valid, err;
  logic [NB-1:0] clr_addr;
  logic [2*NB-1:0] depth;

  int checks = 0, failures = 0, dv_cnt = 0, dv_exp = 0;
  logic [2*NB-1:0] exp_q[$];
  logic [2*NB-1:0] exp_d;

  dtof_acq_sequencer #(.NB(NB), .CYC_CH(CYC), .CYC_FH(CYC), .TIMEOUT(TO)) dut (
    .clk_i(clk), .res_ni(res_n), .start_i(start), .abort_i(abort),
    .tdc_valid_i(tdc_valid), .cyc_end_i(cyc_end), .peak_done_i(peak_done),
    .peak_ch_i(peak_ch), .peak_fh_i(peak_fh), .alg_ready_i(alg_ready),
    .wr_en_o(wr_en), .his_num_o(his_num), .clr_en_o(clr_en), .clr_addr_o(clr_addr),
    .acq_finish_o(acq_finish), .busy_o(busy), .depth_o(depth),
    .depth_valid_o(depth_valid), .err_o(err));

  always #5 clk = ~clk;

  always @(negedge clk) if (depth_valid) dv_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Counts clocks with clr_en high, bounded so a stuck clear cannot hang the run.
  task automatic run_clear(output int n);
    n = 0;
    while (clr_en && n < 100) begin n++; step(); end
  endtask

  // n laser cycles, each with a tdc_valid-only clock ahead of the cyc_end pulse.
  task automatic run_acq(input int n);
    for (int i = 0; i < n; i++) begin
      tdc_valid = 1; step(); tdc_valid = 0;
      cyc_end = 1; step(); cyc_end = 0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({wr_en, his_num, clr_en, clr_addr, acq_finish, busy, depth, depth_valid, err} !== '0) begin
      failures++; $display("FAIL reset_outputs got busy=%b clr_en=%b depth=%h err=%b want all 0", busy, clr_en, depth, err);
    end
    step(); res_n = 1; step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_nominal();
    int n;
    start = 1; step(); start = 0;
    checks++;
    if ({clr_en, busy, his_num, clr_addr} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      failures++; $display("FAIL nom_clr_entry got clr_en=%b busy=%b his=%b addr=%0d want 1 1 0 0", clr_en, busy, his_num, clr_addr);
    end
    run_clear(n);
    checks++;
    if (n != 32) begin failures++; $display("FAIL nom_clr_len got %0d want 32", n); end
    run_acq(CYC - 1);
    checks++;
    if (busy !== 1'b1 || acq_finish !== 1'b0) begin
      failures++; $display("FAIL nom_acq_partial got busy=%b fin=%b want 1 0", busy, acq_finish);
    end
    tdc_valid = 1; cyc_end = 1; #1;
    checks++;
    if (wr_en !== 1'b1) begin failures++; $display("FAIL last_cyc_wr got %b want 1", wr_en); end
    step(); cyc_end = 0; #1;
    checks++;
    if (wr_en !== 1'b0 || acq_finish !== 1'b1) begin
      failures++; $display("FAIL after_last_cyc got wr_en=%b fin=%b want 0 1", wr_en, acq_finish);
    end
    tdc_valid = 0; step();
    checks++;
    if (acq_finish !== 1'b0) begin failures++; $display("FAIL fin_pulse_len got %b want 0", acq_finish); end
    peak_ch = 5'd7; peak_done = 1; step(); peak_done = 0; peak_ch = '0;
    step();
    checks++;
    if ({busy, his_num, clr_en} !== 3'b100) begin
      failures++; $display("FAIL nom_wait_alg got busy=%b his=%b clr=%b want 1 0 0", busy, his_num, clr_en);
    end
    alg_ready = 1; step(); alg_ready = 0;
    checks++;
    if ({clr_en, his_num, clr_addr} !== {1'b1, 1'b1, 5'd0}) begin
      failures++; $display("FAIL nom_clr_fh got clr=%b his=%b addr=%0d want 1 1 0", clr_en, his_num, clr_addr);
    end
    run_clear(n);
    checks++;
    if (n != 32) begin failures++; $display("FAIL nom_clr_fh_len got %0d want 32", n); end
    run_acq(CYC);
    checks++;
    if (acq_finish !== 1'b1 || his_num !== 1'b1) begin
      failures++; $display("FAIL nom_fh_finish got fin=%b his=%b want 1 1", acq_finish, his_num);
    end
    exp_q.push_back({5'd7, 5'd19}); dv_exp++;
    peak_fh = 5'd19; peak_done = 1; step(); peak_done = 0; peak_fh = '0;
    exp_d = exp_q.pop_front();
    checks++;
    if (depth_valid !== 1'b1 || depth !== exp_d || busy !== 1'b0 || his_num !== 1'b0) begin
      failures++; $display("FAIL nom_depth got dv=%b depth=%h busy=%b his=%b want 1 %h 0 0", depth_valid, depth, busy, his_num, exp_d);
    end
    step();
    checks++;
    if (depth_valid !== 1'b0 || depth !== exp_d) begin
      failures++; $display("FAIL nom_depth_hold got dv=%b depth=%h want 0 %h", depth_valid, depth, exp_d);
    end
  endtask

  task automatic test_timeout();
    int n;
    start = 1; step(); start = 0;
    run_clear(n); run_acq(CYC);
    repeat (TO - 1) step();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_early got busy=%b err=%b want 1 0", busy, err); end
    step();
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || depth !== 10'h0F3 || his_num !== 1'b0) begin
      failures++; $display("FAIL to_expire got busy=%b err=%b depth=%h want 0 1 0f3", busy, err, depth);
    end
    checks++;
    if (dv_cnt != dv_exp) begin failures++; $display("FAIL to_no_dv got %0d pulses want %0d", dv_cnt, dv_exp); end
  endtask

  task automatic test_abort_priority();
    abort = 1; start = 1; step(); abort = 0; start = 0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || clr_en !== 1'b0) begin
      failures++; $display("FAIL abort_over_start got busy=%b err=%b clr=%b want 0 1 0", busy, err, clr_en);
    end
  endtask

  task automatic test_restart_abort();
    int n;
    start = 1; step(); start = 0;
    checks++;
    if ({err, busy, clr_en, clr_addr} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin
      failures++; $display("FAIL restart_clr_err got err=%b busy=%b clr=%b addr=%0d want 0 1 1 0", err, busy, clr_en, clr_addr);
    end
    repeat (5) step();
    start = 1; step(); start = 0;
    checks++;
    if (clr_addr !== 5'd6) begin failures++; $display("FAIL start_busy_ignored got addr=%0d want 6", clr_addr); end
    run_clear(n);
    checks++;
    if (n != 26) begin failures++; $display("FAIL restart_clr_rest got %0d want 26", n); end
    run_acq(CYC);
    peak_ch = 5'd3; peak_done = 1; alg_ready = 1; step(); peak_done = 0;
    checks++;
    if ({busy, his_num, clr_en} !== 3'b100) begin
      failures++; $display("FAIL alg_early_wait got busy=%b his=%b clr=%b want 1 0 0", busy, his_num, clr_en);
    end
    step(); alg_ready = 0;
    checks++;
    if ({clr_en, his_num, clr_addr} !== {1'b1, 1'b1, 5'd0}) begin
      failures++; $display("FAIL alg_early_leave got clr=%b his=%b addr=%0d want 1 1 0", clr_en, his_num, clr_addr);
    end
    repeat (9) step();
    checks++;
    if (clr_addr !== 5'd9) begin failures++; $display("FAIL abort_setup got addr=%0d want 9", clr_addr); end
    abort = 1; peak_done = 1; step(); abort = 0; peak_done = 0;
    checks++;
    if ({clr_en, busy, his_num, err, depth_valid} !== 5'b0) begin
      failures++; $display("FAIL abort_clr_fh got clr=%b busy=%b his=%b err=%b dv=%b want 0", clr_en, busy, his_num, err, depth_valid);
    end
    step();
    checks++;
    if (busy !== 1'b0 || depth !== 10'h0F3) begin
      failures++; $display("FAIL abort_idle got busy=%b depth=%h want 0 0f3", busy, depth);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [NB-1:0] pc [2];
    logic [NB-1:0] pf [2];
    pc[0] = 5'd31; pf[0] = 5'd0; pc[1] = 5'd0; pf[1] = 5'd31;
    for (int f = 0; f < 2; f++) begin
      start = 1; step(); start = 0;
      run_clear(n);
      checks++;
      if (n != 32) begin failures++; $display("FAIL b2b_clr[%0d] got %0d want 32", f, n); end
      run_acq(CYC);
      peak_ch = pc[f]; peak_done = 1; step(); peak_done = 0; peak_ch = '0;
      alg_ready = 1; step(); alg_ready = 0;
      run_clear(n); run_acq(CYC);
      exp_q.push_back({pc[f], pf[f]}); dv_exp++;
      peak_fh = pf[f]; peak_done = 1; step(); peak_done = 0; peak_fh = '0;
      exp_d = exp_q.pop_front();
      checks++;
      if (depth_valid !== 1'b1 || depth !== exp_d) begin
        failures++; $display("FAIL b2b_depth[%0d] got dv=%b depth=%h want 1 %h", f, depth_valid, depth, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_acq();
    int n;
    start = 1; step(); start = 0;
    run_clear(n); run_acq(CYC);
    peak_ch = 5'd12; peak_done = 1; alg_ready = 1; step(); peak_done = 0; step(); alg_ready = 0;
    run_clear(n); run_acq(2);
    tdc_valid = 1; #1;
    checks++;
    if (wr_en !== 1'b1 || his_num !== 1'b1) begin
      failures++; $display("FAIL rst_setup got wr_en=%b his=%b want 1 1", wr_en, his_num);
    end
    res_n = 0; #1;
    checks++;
    if ({wr_en, his_num, clr_en, clr_addr, acq_finish, busy, depth, depth_valid, err} !== '0) begin
      failures++; $display("FAIL rst_mid_acq got wr_en=%b his=%b busy=%b depth=%h want all 0", wr_en, his_num, busy, depth);
    end
    step(); res_n = 1; tdc_valid = 0; cyc_end = 1; step(); cyc_end = 0;
    checks++;
    if (busy !== 1'b0 || acq_finish !== 1'b0) begin
      failures++; $display("FAIL rst_stays_idle got busy=%b fin=%b want 0 0", busy, acq_finish);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_abort_priority();
    test_restart_abort();
    test_back_to_back();
    test_reset_mid_acq();
    checks++;
    if (dv_cnt != dv_exp || exp_q.size() != 0) begin
      failures++; $display("FAIL dv_total got %0d pulses want %0d (queue left %0d)", dv_cnt, dv_exp, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
